// File: rtl/div_issue_queue.sv
// rtl/div_issue_queue.sv - in-order issue queue and result tagger for the iterative divider (optional memo: DIV_RESULT_CACHE_EN)

package riscv_div_pkg;
  typedef enum logic [2:0] {
    DIV_NONE = 3'd0,
    DIV      = 3'd1,
    DIVU     = 3'd2,
    REM      = 3'd3,
    REMU     = 3'd4
  } riscv_div_op_e;
endpackage

module div_issue_queue
  import riscv_div_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_dataA,
  input  logic [DATA_W-1:0] req_dataB,
  input  riscv_div_op_e     req_op,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              div_req_valid,
  input  logic              div_req_ready,
  output logic [DATA_W-1:0] div_req_dataA,
  output logic [DATA_W-1:0] div_req_dataB,
  output riscv_div_op_e     div_req_op,
  input  logic              div_rsp_valid,
  output logic              div_rsp_ready,
  input  logic [DATA_W-1:0] div_rsp_result,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_result,
  output logic [TAG_W-1:0]  wb_tag,
  output logic              wb_hit
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_e;

  logic [DATA_W-1:0] q_a   [QDEPTH];
  logic [DATA_W-1:0] q_b   [QDEPTH];
  riscv_div_op_e     q_op  [QDEPTH];
  logic [TAG_W-1:0]  q_tag [QDEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              full, push, pop;

  state_e            state;
  logic              squash;
  logic [DATA_W-1:0] inf_a, inf_b;
  riscv_div_op_e     inf_op;
  logic [TAG_W-1:0]  inf_tag;
  logic [DATA_W-1:0] wb_result_q;
  logic [TAG_W-1:0]  wb_tag_q;
  logic              wb_hit_q;

  logic [DATA_W-1:0] head_a, head_b;
  riscv_div_op_e     head_op;
  logic [TAG_W-1:0]  head_tag;
  logic              cache_hit;
  logic [DATA_W-1:0] cache_rd;

  assign full      = (count == DEPTH_C);
  assign req_ready = !full && !flush;
  assign push      = req_valid && req_ready;
  // The FSM only pops while idle, and never in a flush cycle.
  assign pop       = (state == S_IDLE) && (count != '0) && !flush;

  assign head_a   = q_a[rd_ptr];
  assign head_b   = q_b[rd_ptr];
  assign head_op  = q_op[rd_ptr];
  assign head_tag = q_tag[rd_ptr];

  assign div_req_valid = (state == S_ISSUE);
  assign div_req_dataA = inf_a;
  assign div_req_dataB = inf_b;
  assign div_req_op    = inf_op;
  assign div_rsp_ready = (state == S_BUSY);
  assign wb_valid      = (state == S_RESP);
  assign wb_result     = wb_result_q;
  assign wb_tag        = wb_tag_q;
  assign wb_hit        = wb_hit_q;

`ifdef DIV_RESULT_CACHE_EN
  logic              cache_valid;
  logic [DATA_W-1:0] cache_a, cache_b, cache_result;
  riscv_div_op_e     cache_op;

  assign cache_hit = cache_valid && (cache_a == head_a) && (cache_b == head_b) && (cache_op == head_op);
  assign cache_rd  = cache_result;

  // One-entry memo of the last divider result that was actually delivered.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cache_valid  <= 1'b0;
      cache_a      <= '0;
      cache_b      <= '0;
      cache_op     <= DIV_NONE;
      cache_result <= '0;
    end else if (state == S_BUSY && div_rsp_valid && !squash) begin
      cache_valid  <= 1'b1;
      cache_a      <= inf_a;
      cache_b      <= inf_b;
      cache_op     <= inf_op;
      cache_result <= div_rsp_result;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_rd  = '0;
`endif

  // Queue payload storage; written only on an accepted request.
  always_ff @(posedge clk) begin
    if (push) begin
      q_a[wr_ptr]   <= req_dataA;
      q_b[wr_ptr]   <= req_dataB;
      q_op[wr_ptr]  <= req_op;
      q_tag[wr_ptr] <= req_tag;
    end
  end

  // Queue pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue/response FSM: one divide in flight, squash tracks a response owed after flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      squash      <= 1'b0;
      inf_a       <= '0;
      inf_b       <= '0;
      inf_op      <= DIV_NONE;
      inf_tag     <= '0;
      wb_result_q <= '0;
      wb_tag_q    <= '0;
      wb_hit_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            inf_a   <= head_a;
            inf_b   <= head_b;
            inf_op  <= head_op;
            inf_tag <= head_tag;
            if (head_op == DIV_NONE) begin
              wb_result_q <= '0;
              wb_tag_q    <= head_tag;
              wb_hit_q    <= 1'b1;
              state       <= S_RESP;
            end else if (cache_hit) begin
              wb_result_q <= cache_rd;
              wb_tag_q    <= head_tag;
              wb_hit_q    <= 1'b1;
              state       <= S_RESP;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (div_req_ready) begin
            state <= S_BUSY;
            if (flush) squash <= 1'b1;
          end else if (flush) begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (div_rsp_valid) begin
            if (squash || flush) begin
              squash <= 1'b0;
              state  <= S_IDLE;
            end else begin
              wb_result_q <= div_rsp_result;
              wb_tag_q    <= inf_tag;
              wb_hit_q    <= 1'b0;
              state       <= S_RESP;
            end
          end else if (flush) begin
            squash <= 1'b1;
          end
        end
        S_RESP: begin
          if (flush || wb_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
